// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type, default parameters and clog2 for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DW_DEF        = 8;
    localparam int NSRC_DEF      = 4;
    localparam int MAX_BURST_DEF = 4;

    // Ceiling log2, floored at 1 so index and counter fields never become zero width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// rtl/rr_next_sel.sv - combinational round-robin picker starting after the last granted index
module rr_next_sel
    import fifo_arb_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int IW   = clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            any,
    output logic [IW-1:0]   sel_idx
);

    logic [IW-1:0] idx;

    always_comb begin
        any     = |req;
        sel_idx = '0;
        idx     = '0;
        // Walk farthest-to-nearest so the requester closest after last is assigned last and wins.
        for (int k = NSRC; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NSRC);
            if (req[idx]) begin
                sel_idx = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing the async FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NSRC      = NSRC_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               arb_en,
    input  logic [NSRC-1:0]    src_valid,
    input  logic [NSRC*DW-1:0] src_data,
    input  logic [NSRC-1:0]    src_last,
    output logic [NSRC-1:0]    src_ready,
    output logic               wreq,
    output logic [DW-1:0]      wdata,
    input  logic               wfull,
    output logic [NSRC-1:0]    grant_oh,
    output logic               busy
);

    localparam int              IW        = clog2(NSRC);
    localparam int              BW        = clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0]   LAST_SRC  = IW'(NSRC - 1);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] last_grant, last_grant_nxt;
    logic [BW-1:0] burst_cnt, burst_cnt_nxt;
    logic          any_req;
    logic [IW-1:0] pick;
    logic          g_valid;
    logic          g_last;
    logic [DW-1:0] g_data;
    logic          xfer;

    rr_next_sel #(
        .NSRC (NSRC),
        .IW   (IW)
    ) u_sel (
        .req     (src_valid),
        .last    (last_grant),
        .any     (any_req),
        .sel_idx (pick)
    );

    // last_grant doubles as the current grant index while in GRANT.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (last_grant == IW'(i)) begin
                g_valid = src_valid[i];
                g_last  = src_last[i];
                g_data  = src_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state      <= IDLE;
            last_grant <= LAST_SRC;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        burst_cnt_nxt  = burst_cnt;
        xfer           = 1'b0;
        wreq           = 1'b0;
        wdata          = '0;
        src_ready      = '0;
        grant_oh       = '0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                if (arb_en && any_req) begin
                    state_nxt      = GRANT;
                    last_grant_nxt = pick;
                    burst_cnt_nxt  = '0;
                end
            end
            GRANT: begin
                busy  = 1'b1;
                wdata = g_data;
                for (int i = 0; i < NSRC; i++) begin
                    grant_oh[i]  = (last_grant == IW'(i));
                    src_ready[i] = (last_grant == IW'(i)) && !wfull;
                end
                xfer = g_valid && !wfull;
                wreq = xfer;
                // Clearing on release keeps the counter within 0..MAX_BURST-1.
                if (xfer) begin
                    if (g_last || burst_cnt == LAST_BEAT) begin
                        state_nxt     = IDLE;
                        burst_cnt_nxt = '0;
                    end else begin
                        burst_cnt_nxt = burst_cnt + BW'(1);
                    end
                end else if (!g_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NSRC      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic               wclk      = 1'b0;
    logic               wrst_n    = 1'b1;
    logic               arb_en    = 1'b0;
    logic               wfull     = 1'b0;
    logic [NSRC-1:0]    src_valid = '0;
    logic [NSRC*DW-1:0] src_data  = '0;
    logic [NSRC-1:0]    src_last  = '0;
    logic [NSRC-1:0]    src_ready;
    logic               wreq;
    logic [DW-1:0]      wdata;
    logic [NSRC-1:0]    grant_oh;
    logic               busy;

    fifo_wr_arbiter #(
        .NSRC      (NSRC),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .arb_en    (arb_en),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_ready (src_ready),
        .wreq      (wreq),
        .wdata     (wdata),
        .wfull     (wfull),
        .grant_oh  (grant_oh),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    int              checks = 0;
    int              errors = 0;
    logic [DW:0]     src_q [NSRC][$];
    logic [DW-1:0]   ref_q [NSRC][$];
    logic [NSRC-1:0] src_en = '1;
    logic [NSRC-1:0] took   = '0;
    logic [DW-1:0]   wr_log[$];
    int              grant_log[$];
    int              stall_cnt = 0;
    logic            prev_busy = 1'b0;

    // Reference: one grant at a time, counted in words, next owner chosen by round-robin search.
    bit m_active = 1'b0;
    int m_g      = 0;
    int m_last   = NSRC - 1;
    int m_words  = 0;

    function automatic bit bitof(input logic [NSRC-1:0] v, input int i);
        return ((v >> i) & NSRC'(1)) != '0;
    endfunction

    function automatic int rr_pick(input int last, input logic [NSRC-1:0] v);
        for (int k = 1; k <= NSRC; k++) begin
            if (bitof(v, (last + k) % NSRC)) return (last + k) % NSRC;
        end
        return -1;
    endfunction

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            m_active <= 1'b0;
            m_last   <= NSRC - 1;
            m_words  <= 0;
        end else if (m_active) begin
            if (bitof(src_valid, m_g) && !wfull) begin
                m_words <= m_words + 1;
                if (bitof(src_last, m_g) || m_words + 1 == MAX_BURST) m_active <= 1'b0;
            end else if (!bitof(src_valid, m_g)) begin
                m_active <= 1'b0;
            end
        end else if (arb_en && src_valid != '0) begin
            m_active <= 1'b1;
            m_words  <= 0;
            m_g      <= rr_pick(m_last, src_valid);
            m_last   <= rr_pick(m_last, src_valid);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [NSRC-1:0] v);
        for (int k = 0; k < NSRC; k++) if (v == (NSRC'(1) << k)) return k;
        return -1;
    endfunction

    function automatic int glog(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    function automatic int wlog(input int i);
        return (i < wr_log.size()) ? int'(wr_log[i]) : -1;
    endfunction

    task automatic sample();
        logic [NSRC-1:0] e_goh, e_rdy;
        logic            e_wreq;
        logic [DW-1:0]   e_wdata;
        e_goh   = m_active ? (NSRC'(1) << m_g) : '0;
        e_wreq  = m_active && bitof(src_valid, m_g) && !wfull;
        e_wdata = m_active ? DW'(src_data >> (m_g * DW)) : '0;
        e_rdy   = (m_active && !wfull) ? (NSRC'(1) << m_g) : '0;
        chk("grant_oh", 32'(grant_oh), 32'(e_goh));
        chk("busy", 32'(busy), 32'(m_active));
        chk("wreq", 32'(wreq), 32'(e_wreq));
        chk("wdata", 32'(wdata), 32'(e_wdata));
        chk("src_ready", 32'(src_ready), 32'(e_rdy));
        if (e_wreq) begin
            if (ref_q[m_g].size() == 0) chk("word_available", 0, 1);
            else chk("word_order", 32'(wdata), 32'(ref_q[m_g].pop_front()));
        end
        if (wreq === 1'b1) wr_log.push_back(wdata);
        if (busy === 1'b1 && prev_busy !== 1'b1) grant_log.push_back(onehot_idx(grant_oh));
        if (busy === 1'b1 && wreq !== 1'b1) stall_cnt++;
        prev_busy = busy;
        took = src_valid & src_ready;
    endtask

    task automatic drive();
        logic [NSRC-1:0]    v, l;
        logic [NSRC*DW-1:0] d;
        logic [DW:0]        w;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (bitof(took, i) && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                w = src_q[i][0];
                d = d | ((NSRC*DW)'(w[DW-1:0]) << (i * DW));
                if (w[DW]) l = l | (NSRC'(1) << i);
                if (bitof(src_en, i)) v = v | (NSRC'(1) << i);
            end
        end
        src_valid = v;
        src_data  = d;
        src_last  = l;
    endtask

    task automatic step();
        @(negedge wclk);
        sample();
        @(posedge wclk);
        #2;
        drive();
        #1;
    endtask

    task automatic push(input int s, input logic [DW-1:0] d, input logic l);
        src_q[s].push_back({l, d});
        ref_q[s].push_back(d);
    endtask

    task automatic rst_clear();
        wrst_n = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src_q[i].delete();
            ref_q[i].delete();
        end
        step();
        step();
        wrst_n = 1'b1;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (wr_log.size() < n && c < budget) begin
            step();
            c++;
        end
        chk(name, 32'(wr_log.size() >= n), 1);
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (grant_log.size() < n && c < budget) begin
            step();
            c++;
        end
        chk(name, 32'(grant_log.size() >= n), 1);
    endtask

    initial begin
        int w0, g0, s0;
        int exp_order[5];
        logic [7:0] t2_words[5];
        exp_order = '{0, 1, 2, 3, 0};
        t2_words  = '{8'd15, 8'd19, 8'd107, 8'd5, 8'd8};

        #5 wrst_n = 1'b0;
        step();
        step();
        chk("rst_grant_oh", 32'(grant_oh), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wreq", 32'(wreq), 0);
        chk("rst_src_ready", 32'(src_ready), 0);
        chk("rst_no_write", 32'(wr_log.size()), 0);
        wrst_n = 1'b1;
        arb_en = 1'b1;

        // Lone source 2: four-word burst, bubble, regrant for the fifth word.
        w0 = wr_log.size();
        g0 = grant_log.size();
        for (int j = 0; j < 5; j++) push(2, t2_words[j], 1'b0);
        wait_writes(w0 + 5, 40, "t2_timeout");
        repeat (3) step();
        for (int j = 0; j < 5; j++) chk("t2_word", 32'(wlog(w0 + j)), 32'(t2_words[j]));
        chk("t2_grant0", 32'(glog(g0)), 2);
        chk("t2_grant1", 32'(glog(g0 + 1)), 2);
        chk("t2_write_count", 32'(wr_log.size() - w0), 5);

        // All sources busy: rotation 0,1,2,3,0 with four words per grant.
        rst_clear();
        w0 = wr_log.size();
        g0 = grant_log.size();
        for (int s = 0; s < NSRC; s++)
            for (int j = 0; j < 8; j++) push(s, 8'(s * 16 + j), 1'b0);
        wait_writes(w0 + 20, 150, "t3_timeout");
        for (int k = 0; k < 5; k++) chk("t3_grant_order", 32'(glog(g0 + k)), 32'(exp_order[k]));
        for (int k = 0; k < 20; k++)
            chk("t3_word", 32'(wlog(w0 + k)), 32'(exp_order[k / 4] * 16 + (k / 16) * 4 + k % 4));

        // Reset in the middle of source 2's burst; source 0 must win afterwards.
        for (int j = 8; j < 12; j++) push(0, 8'(j), 1'b0);
        wait_grants(g0 + 7, 80, "t6_timeout");
        chk("t6_grant_before_reset", 32'(glog(g0 + 6)), 2);
        wrst_n = 1'b0;
        #1;
        chk("t6_rst_grant_oh", 32'(grant_oh), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_wreq", 32'(wreq), 0);
        chk("t6_rst_src_ready", 32'(src_ready), 0);
        chk("t6_rst_wdata", 32'(wdata), 0);
        step();
        wrst_n = 1'b1;
        g0 = grant_log.size();
        wait_grants(g0 + 1, 20, "t6_regrant_timeout");
        chk("t6_first_grant", 32'(glog(g0)), 0);

        // Source 1 stalled by wfull for three cycles after its second word.
        rst_clear();
        w0 = wr_log.size();
        for (int j = 0; j < 4; j++) push(1, 8'(16 + j), 1'b0);
        wait_writes(w0 + 2, 20, "t4_first_timeout");
        s0 = stall_cnt;
        wfull = 1'b1;
        repeat (3) step();
        wfull = 1'b0;
        wait_writes(w0 + 4, 20, "t4_rest_timeout");
        repeat (4) step();
        chk("t4_stall_cycles", 32'(stall_cnt - s0), 3);
        chk("t4_write_count", 32'(wr_log.size() - w0), 4);
        for (int j = 0; j < 4; j++) chk("t4_word", 32'(wlog(w0 + j)), 32'(16 + j));

        // src_last on source 1's second word hands over to waiting source 3.
        rst_clear();
        w0 = wr_log.size();
        g0 = grant_log.size();
        push(1, 8'h21, 1'b0);
        push(1, 8'h22, 1'b1);
        push(1, 8'h23, 1'b0);
        wait_grants(g0 + 1, 20, "t5_grant_timeout");
        push(3, 8'h31, 1'b0);
        push(3, 8'h32, 1'b1);
        wait_grants(g0 + 2, 20, "t5_handover_timeout");
        chk("t5_first_grant", 32'(glog(g0)), 1);
        chk("t5_next_grant", 32'(glog(g0 + 1)), 3);
        wait_writes(w0 + 5, 30, "t5_drain_timeout");
        chk("t5_word0", 32'(wlog(w0)), 32'h21);
        chk("t5_word1", 32'(wlog(w0 + 1)), 32'h22);
        chk("t5_word2", 32'(wlog(w0 + 2)), 32'h31);

        // Randomized traffic with withdrawals, back-pressure and arb_en gaps.
        rst_clear();
        for (int c = 0; c < 3000; c++) begin
            wfull  = ($urandom_range(0, 4) == 0);
            arb_en = ($urandom_range(0, 9) != 0);
            for (int s = 0; s < NSRC; s++) begin
                if ($urandom_range(0, 9) == 0) src_en = src_en & ~(NSRC'(1) << s);
                else src_en = src_en | (NSRC'(1) << s);
                if (src_q[s].size() < 3) push(s, 8'($urandom), ($urandom_range(0, 4) == 0));
            end
            step();
        end
        src_en = '1;
        wfull  = 1'b0;
        arb_en = 1'b1;
        for (int c = 0; c < 200; c++) step();
        for (int s = 0; s < NSRC; s++) chk("rand_drained", 32'(ref_q[s].size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
